// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions for the iterative multiplier: FSM states,
// iteration count and status-register flag positions.
package exe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    localparam int MUL_ITER = 32;

    // Bit positions inside the {N,Z,C,V} nibble, matching the status register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_multiplier_if.sv
// Request/response bundle between the EXE stage (master) and the
// multiplier (slave), including the status-register write port.
interface exe_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             accumulate;
    logic             s_in;
    logic             c_in;
    logic             v_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       status_bits;
    logic             status_we;

    modport master (
        output start, flush, op_a, op_b, acc, accumulate, s_in, c_in, v_in,
        input  busy, done, result, status_bits, status_we
    );

    modport slave (
        input  start, flush, op_a, op_b, acc, accumulate, s_in, c_in, v_in,
        output busy, done, result, status_bits, status_we
    );
endinterface

// File: rtl/exe_multiplier.sv
// Iterative shift-add MUL/MLA unit: one multiplier bit per cycle, an extra
// cycle for the accumulate add, then a one-cycle done/status-write pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last completed result
// CALC  | one shift-add step per cycle, ITER cycles
// FIN   | optional accumulate add, result/flags registered
// DONE  | done pulse, status_we = latched S bit
module exe_multiplier
    import exe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = MUL_ITER
) (
    input  logic               clk,
    input  logic               rst_n,
    exe_multiplier_if.slave    bus
);

    localparam int CNT_W = $clog2(ITER + 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             accum_q, accum_d;
    logic             s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       status_q, status_d;

    logic             take;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] fin_val;

    // DONE hands back to IDLE on the same edge, so a request presented during
    // the DONE cycle is taken back-to-back without losing an edge.
    assign take    = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign addend  = (state_q == ST_FIN) ? acc_q : mcand_q;
    assign sum     = partial_q + addend;
    assign fin_val = accum_q ? sum : partial_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partial_d = partial_q;
        acc_d     = acc_q;
        accum_d   = accum_q;
        s_d       = s_q;
        c_d       = c_q;
        v_d       = v_q;
        result_d  = result_q;
        status_d  = status_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (take) begin
                    mcand_d   = bus.op_a;
                    mplier_d  = bus.op_b;
                    acc_d     = bus.acc;
                    accum_d   = bus.accumulate;
                    s_d       = bus.s_in;
                    c_d       = bus.c_in;
                    v_d       = bus.v_in;
                    partial_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (mplier_q[0]) partial_d = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIN;
            end
            ST_FIN: begin
                partial_d        = fin_val;
                result_d         = fin_val;
                status_d[FLAG_N] = fin_val[WIDTH-1];
                status_d[FLAG_Z] = (fin_val == '0);
                status_d[FLAG_C] = c_q;
                status_d[FLAG_V] = v_q;
                state_d          = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush aborts everything, including a FIN that would publish a result
        if (bus.flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
            status_d = status_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            acc_q     <= '0;
            accum_q   <= 1'b0;
            s_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            result_q  <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            partial_q <= partial_d;
            acc_q     <= acc_d;
            accum_q   <= accum_d;
            s_q       <= s_d;
            c_q       <= c_d;
            v_q       <= v_d;
            result_q  <= result_d;
            status_q  <= status_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.status_we   = (state_q == ST_DONE) && s_q;
    assign bus.result      = result_q;
    assign bus.status_bits = status_q;

endmodule

// File: tb/tb_exe_multiplier.sv
// Directed checks of the iterative multiplier: cycle-exact latency, flags,
// status-write gating, ignored start, back-to-back, flush and async reset.
module tb_exe_multiplier;
    import exe_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic seen;

    exe_multiplier_if #(.WIDTH(32)) bus ();

    exe_multiplier #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ac,
                         input logic accum, input logic s, input logic c, input logic v);
        bus.op_a       = a;
        bus.op_b       = b;
        bus.acc        = ac;
        bus.accumulate = accum;
        bus.s_in       = s;
        bus.c_in       = c;
        bus.v_in       = v;
        bus.start      = 1'b1;
    endtask

    // Full operation: start accepted at E0, done checked exactly at E33..E34
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ac, input logic accum, input logic s,
                         input logic c, input logic v,
                         input logic [31:0] exp_res, input logic [3:0] exp_st);
        @(negedge clk);
        drive(a, b, ac, accum, s, c, v);
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
        repeat (32) @(posedge clk);
        #1 chk({tag, "_done_e32"}, 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_status"}, 32'(bus.status_bits), 32'(exp_st));
        chk({tag, "_we"}, 32'(bus.status_we), 32'(s));
        @(posedge clk);
        #1;
        chk({tag, "_done_e34"}, 32'(bus.done), 32'd0);
        chk({tag, "_we_e34"}, 32'(bus.status_we), 32'd0);
        chk({tag, "_busy_e34"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_we", 32'(bus.status_we), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_status", 32'(bus.status_bits), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mul7x6", 32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd42, 4'b0010);
        do_op("mla_wrap", 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 4'b0101);
        do_op("mul_ovf", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'b0100);

        // MUL 0x80000000 x 1, stray start at E5, back-to-back start at E34
        @(negedge clk);
        drive(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 drive(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (27) @(posedge clk);
        #1 chk("neg_done_e32", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        chk("neg_done", 32'(bus.done), 32'd1);
        chk("neg_result", bus.result, 32'h8000_0000);
        chk("neg_status", 32'(bus.status_bits), 32'h8);
        chk("neg_we", 32'(bus.status_we), 32'd1);
        drive(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("b2b_busy_e34", 32'(bus.busy), 32'd1);
        chk("b2b_done_e34", 32'(bus.done), 32'd0);
        repeat (32) @(posedge clk);
        #1 chk("b2b_done_early", 32'(bus.done), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_done", 32'(bus.done), 32'd1);
        chk("b2b_result", bus.result, 32'd9);
        chk("b2b_status", 32'(bus.status_bits), 32'h0);
        chk("b2b_we", 32'(bus.status_we), 32'd0);
        @(posedge clk);

        // Flush at E10: never completes, previous result (9) survives
        @(negedge clk);
        drive(32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (bus.done || bus.status_we || bus.busy) seen = 1'b1;
        end
        chk("flush_no_done", 32'(seen), 32'd0);
        chk("flush_result", bus.result, 32'd9);
        chk("flush_status", 32'(bus.status_bits), 32'h0);

        // Async reset mid-CALC at E15
        @(negedge clk);
        drive(32'd9, 32'd9, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1 chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_we", 32'(bus.status_we), 32'd0);
        chk("mid_rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("mul3x5", 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd15, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_multiplier.md
# exe_multiplier

Iterative 32×32 multiply / multiply-accumulate unit in the EXE stage of the ARM 32-bit pipeline. It runs MUL/MLA over several cycles with a shift-add datapath. While it runs it stalls the pipeline through `busy`. When it finishes it presents the low 32 bits of the product and an NZCV nibble to the status register. That nibble comes with a write strobe that follows the instruction's S bit.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width
- `ITER`, 32, shift-add iterations (equals `WIDTH`)

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  multiply request from EXE; honoured only in IDLE
- `flush`  in  1  pipeline flush; aborts any operation in progress
- `op_a`  in  WIDTH  multiplicand (Rm)
- `op_b`  in  WIDTH  multiplier (Rs)
- `acc`  in  WIDTH  accumulate operand (Rn)
- `accumulate`  in  1  1 = MLA, 0 = MUL
- `s_in`  in  1  S bit of the instruction
- `c_in`  in  1  current C flag (passed through)
- `v_in`  in  1  current V flag (passed through)
- `busy`  out  1  operation in progress; pipeline freeze request
- `done`  out  1  one-cycle completion pulse
- `result`  out  WIDTH  product (plus acc) bits [31:0]
- `status_bits`  out  4  {N,Z,C,V} for the status register
- `status_we`  out  1  status register write enable (`s` of status register)

## Operation
- FSM states: IDLE, CALC, FIN, DONE.
- IDLE + `start`:
  - latch `op_a`, `op_b`, `acc`, `accumulate`, `s_in`, `c_in`, `v_in`;
  - clear partial product; counter = 0; go to CALC.
- CALC, once per cycle:
  - if the multiplier LSB = 1, partial += multiplicand;
  - multiplicand <<= 1, multiplier >>= 1, counter++;
  - after ITER iterations, go to FIN.
- FIN: partial += latched acc when accumulate = 1; go to DONE.
- DONE: `done`=1; `status_we` = latched s; go to IDLE.
- Arithmetic is modulo 2^32. The upper product bits are discarded and no carry-out is recorded.
- Flags:
  - N = result[31];
  - Z = (result == 0);
  - C = latched c_in;
  - V = latched v_in.
- `busy` = (state != IDLE), combinational.
- `start` while busy is ignored; it has no effect on the running operation.
- `flush` in any state: next edge goes to IDLE; no `done`, no `status_we`; latched data discarded.
- `flush` and `start` in the same IDLE cycle: flush wins, request dropped.
- `result`/`status_bits` hold their last completed value until the next DONE. They are not cleared by flush.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, counter = 0;
  - `result` = 0, `status_bits` = 0;
  - `busy` = 0, `done` = 0, `status_we` = 0.
  - Applies immediately, including mid-operation.
- Start accepted at rising edge E0.
- CALC occupies edges E1..E32; FIN occupies edge E33.
- DONE cycle is E33→E34:
  - `done`, `status_we`, `result` and `status_bits` are valid and stable for that whole cycle;
  - the status register's falling-edge capture lands inside it.
- IDLE from E34. A new `start` may be accepted at E34 (back-to-back); latency is fixed at 34 edges.
- `busy` is high from E0 through E34 exclusive. The pipeline must hold EXE inputs stable only at E0.
- `done`/`status_we` are never high for more than one cycle. `status_we` is never high without `done`.

## Structure
- Shared `exe_pkg` holds:
  - the FSM state enum (IDLE, CALC, FIN, DONE);
  - `MUL_ITER` = 32;
  - flag index constants N=3, Z=2, C=1, V=0, matching the status register's bit order.
- Single module; no sub-module.
- The shift-add step stays inline; the only adders are the 32-bit partial adder and its reuse for the acc add in FIN.

## Test plan
- MUL 7×6, s_in=1, c_in=1, v_in=0 → at E33–E34: result=42, status_bits=4'b0010, status_we=1, done one cycle.
- MLA 0xFFFFFFFF×1 + acc=1, s_in=1, c_in=0, v_in=1 → result=0, status_bits=4'b0101.
- MUL 0x00010000×0x00010000, s_in=0 → result=0, status_bits=4'b0100, status_we=0, done=1.
- MUL 0x80000000×1 → result=0x80000000, N=1; second `start` pulsed at E5 is ignored; new `start` at E34 is accepted, and its done comes 34 edges later.
- `flush` at E10 of a MUL → busy low after that edge; no done or status_we ever; result holds the previous value.
- `rst_n` low mid-CALC (E15) → busy, done, status_we and result all 0 immediately; after release, MUL 3×5 gives 15.
